// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer: issues req/ack fetches at pc,
// hands fetched words to decode with a valid/stall handshake, and applies redirects.
module pc_fetch_sequencer #(
    parameter int                 WIDTH    = 16,
    parameter logic [WIDTH-1:0]   RESET_PC = 16'h0100,
    parameter int                 INC      = 2
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] pc
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] pc_r, pc_s;
    logic [WIDTH-1:0] instr_r, instr_s;
    logic             instr_valid_r, instr_valid_s;
    logic             imem_req_r, imem_req_s;
    logic             redirect_pending_r, redirect_pending_s;
    logic [WIDTH-1:0] pend_target_r, pend_target_s;

    // Next-state and next-output computation for the fetch FSM
    always_comb begin
        state_s            = state_r;
        pc_s               = pc_r;
        instr_s            = instr_r;
        instr_valid_s      = instr_valid_r;
        redirect_pending_s = redirect_pending_r;
        pend_target_s      = pend_target_r;
        case (state_r)
            S_RESET: begin
                instr_valid_s = 1'b0;
                state_s       = S_REQ;
            end
            S_REQ: begin
                // pc is frozen until ack so the address seen by memory never moves
                if (imem_ack) begin
                    if (redirect) begin
                        pc_s               = redirect_target;
                        redirect_pending_s = 1'b0;
                    end else if (redirect_pending_r) begin
                        pc_s               = pend_target_r;
                        redirect_pending_s = 1'b0;
                    end else begin
                        instr_s       = imem_rdata;
                        instr_valid_s = 1'b1;
                        state_s       = S_HOLD;
                    end
                end else if (redirect) begin
                    redirect_pending_s = 1'b1;
                    pend_target_s      = redirect_target;
                end else begin
                    redirect_pending_s = redirect_pending_r;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_s          = redirect_target;
                    instr_valid_s = 1'b0;
                    state_s       = S_REQ;
                end else if (!stall) begin
                    pc_s          = pc_r + WIDTH'(INC);
                    instr_valid_s = 1'b0;
                    state_s       = S_REQ;
                end else begin
                    instr_valid_s = instr_valid_r;
                end
            end
            default: begin
                instr_valid_s = 1'b0;
                state_s       = S_RESET;
            end
        endcase
        imem_req_s = (state_s == S_REQ);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r            <= S_RESET;
            pc_r               <= RESET_PC;
            instr_r            <= {WIDTH{1'b0}};
            instr_valid_r      <= 1'b0;
            imem_req_r         <= 1'b0;
            redirect_pending_r <= 1'b0;
            pend_target_r      <= {WIDTH{1'b0}};
        end else begin
            state_r            <= state_s;
            pc_r               <= pc_s;
            instr_r            <= instr_s;
            instr_valid_r      <= instr_valid_s;
            imem_req_r         <= imem_req_s;
            redirect_pending_r <= redirect_pending_s;
            pend_target_r      <= pend_target_s;
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed vector table for the corner sequences, then
// randomized traffic checked against a transaction-level fetch model.
module tb_pc_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_target = 16'h0000;
    logic [15:0] pc;

    int n_pass = 0;
    int n_total = 0;

    pc_fetch_sequencer dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .pc(pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [15:0] rdata;
        logic        stl;
        logic        rdr;
        logic [15:0] tgt;
        logic        e_req;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic ack, logic [15:0] rdata, logic stl,
                                logic rdr, logic [15:0] tgt, logic e_req, logic e_valid,
                                logic [15:0] e_pc, logic [15:0] e_instr);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdata = rdata; v.stl = stl; v.rdr = rdr; v.tgt = tgt;
        v.e_req = e_req; v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic check(string name, logic e_req, logic e_valid, logic [15:0] e_pc,
                         logic [15:0] e_instr);
        logic [49:0] act;
        logic [49:0] exp;
        act = {imem_req, instr_valid, pc, imem_addr, instr};
        exp = {e_req, e_valid, e_pc, e_pc, e_instr};
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got req=%b valid=%b pc=%h addr=%h instr=%h, want req=%b valid=%b pc=%h addr=%h instr=%h",
                      name, imem_req, instr_valid, pc, imem_addr, instr,
                      e_req, e_valid, e_pc, e_pc, e_instr);
    endtask

    // Transaction-level model: fresh = first cycle after reset, have = word held for decode
    logic        m_fresh, m_have;
    logic [15:0] m_pc, m_word;
    logic [15:0] pend_q[$];

    task automatic model_step();
        if (reset) begin
            m_fresh = 1'b1; m_have = 1'b0; m_pc = 16'h0100; m_word = 16'h0000;
            pend_q.delete();
        end else if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (!m_have) begin
            if (imem_ack) begin
                if (redirect) begin
                    m_pc = redirect_target;
                    pend_q.delete();
                end else if (pend_q.size() > 0) begin
                    m_pc = pend_q.pop_front();
                end else begin
                    m_have = 1'b1;
                    m_word = imem_rdata;
                end
            end else if (redirect) begin
                pend_q.delete();
                pend_q.push_back(redirect_target);
            end
        end else if (redirect) begin
            m_pc = redirect_target; m_have = 1'b0;
        end else if (!stall) begin
            m_pc = 16'((32'(m_pc) + 32'd2) % 32'd65536); m_have = 1'b0;
        end
    endtask

    initial begin
        // T1: reset, first request, ack after 2 cycles
        vecs.push_back(mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,16'h0100,16'h0000));
        vecs.push_back(mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,16'h0100,16'h0000));
        vecs.push_back(mk(1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,16'h0100,16'h0000));
        vecs.push_back(mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0100,16'h0000));
        vecs.push_back(mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0100,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,16'h1234,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'h0100,16'h1234));
        // T2: stall 4 cycles then consume
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,1'b1,16'h0100,16'h1234));
        vecs.push_back(mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0102,16'h1234));
        // T3: redirect while awaiting ack, stale 0xDEAD discarded
        vecs.push_back(mk(1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0400, 1'b1,1'b0,16'h0102,16'h1234));
        vecs.push_back(mk(1'b0,1'b1,16'hDEAD,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0400,16'h1234));
        vecs.push_back(mk(1'b0,1'b1,16'h5678,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'h0400,16'h5678));
        // T4: redirect beats stall in hold
        vecs.push_back(mk(1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0800, 1'b1,1'b0,16'h0800,16'h5678));
        vecs.push_back(mk(1'b0,1'b1,16'h9ABC,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'h0800,16'h9ABC));
        // Same-cycle redirect with ack discards data; T5 wrap from 0xFFFE
        vecs.push_back(mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0802,16'h9ABC));
        vecs.push_back(mk(1'b0,1'b1,16'h1111,1'b0,1'b1,16'hFFFE, 1'b1,1'b0,16'hFFFE,16'h9ABC));
        vecs.push_back(mk(1'b0,1'b1,16'h2222,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'hFFFE,16'h2222));
        vecs.push_back(mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0000,16'h2222));
        vecs.push_back(mk(1'b0,1'b1,16'h3333,1'b0,1'b0,16'h0000, 1'b0,1'b1,16'h0000,16'h3333));
        // T6: reset in hold with stall, then resume
        vecs.push_back(mk(1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b0,1'b0,16'h0100,16'h0000));
        vecs.push_back(mk(1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 1'b1,1'b0,16'h0100,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,16'h4444,1'b1,1'b0,16'h0000, 1'b0,1'b1,16'h0100,16'h4444));
        // Reset mid-request overrides ack
        vecs.push_back(mk(1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 1'b1,1'b0,16'h0102,16'h4444));
        vecs.push_back(mk(1'b1,1'b1,16'h5555,1'b0,1'b1,16'h0700, 1'b0,1'b0,16'h0100,16'h0000));
        vecs.push_back(mk(1'b0,1'b1,16'h6666,1'b0,1'b1,16'h0900, 1'b1,1'b0,16'h0100,16'h0000));

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
            stall = vecs[i].stl; redirect = vecs[i].rdr; redirect_target = vecs[i].tgt;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_valid,
                  vecs[i].e_pc, vecs[i].e_instr);
        end

        // Randomized traffic; memory acks only while the model says a request is open
        m_fresh = 1'b1; m_have = 1'b0; m_pc = 16'h0100; m_word = 16'h0000;
        reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                reset      = ($urandom_range(0, 99) == 0);
                imem_ack   = !m_fresh && !m_have && ($urandom_range(0, 2) == 0);
                imem_rdata = 16'($urandom);
                stall      = ($urandom_range(0, 2) == 0);
                redirect   = ($urandom_range(0, 7) == 0);
                redirect_target = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom);
            end
            @(posedge clock);
            model_step();
            #1;
            check($sformatf("rand%0d", c), !m_fresh && !m_have, m_have, m_pc, m_word);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
